// File: rtl/ulpi_pkg.sv
// Shared ULPI register-access constants, FSM state type and address helper.
package ulpi_pkg;

    localparam logic [1:0] REGW         = 2'b10;
    localparam logic [1:0] REGR         = 2'b11;
    localparam logic [5:0] EXT_ADDR_ESC = 6'h2F;

    typedef enum logic [3:0] {
        IDLE,
        CMD,
        EXT_ADDR,
        WDATA,
        STP,
        TURN,
        RDATA,
        DONE,
        WAIT_DIR_LOW
    } reg_state_t;

    // Addresses at or above the escape code need the extended two-byte form.
    function automatic logic is_ext_addr(input logic [7:0] addr);
        return addr >= 8'h2F;
    endfunction

endpackage

// File: rtl/ulpi_rxcmd_tracker.sv
// Captures RX CMD bytes the PHY sends while it owns the bus outside a register read.
module ulpi_rxcmd_tracker (
    input  logic       clk,
    input  logic       reset,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    input  logic [7:0] ulpi_data_in,
    input  logic       capture_en,
    output logic       rxcmd_valid,
    output logic [7:0] rxcmd,
    output logic [1:0] line_state
);

    logic       dir_q_reg;
    logic       valid_reg;
    logic [7:0] rxcmd_reg;
    logic [1:0] line_state_reg;
    logic       capture;

    // The first dir=1 cycle is the bus turnaround, so require dir high on the previous cycle too.
    assign capture = ulpi_dir && dir_q_reg && !ulpi_nxt && capture_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q_reg      <= 1'b0;
            valid_reg      <= 1'b0;
            rxcmd_reg      <= 8'h00;
            line_state_reg <= 2'b00;
        end else begin
            dir_q_reg <= ulpi_dir;
            valid_reg <= capture;
            if (capture) begin
                rxcmd_reg      <= ulpi_data_in;
                line_state_reg <= ulpi_data_in[1:0];
            end
        end
    end

    assign rxcmd_valid = valid_reg;
    assign rxcmd       = rxcmd_reg;
    assign line_state  = line_state_reg;

endmodule

// File: rtl/ulpi_reg_ctrl.sv
// ULPI link-side register engine: turns req/done accesses into TX CMD write/read
// sequences with extended addressing, dir-abort retry and stall timeout.
module ulpi_reg_ctrl
    import ulpi_pkg::*;
#(
    parameter int EXT_ADDR_EN    = 1,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ulpi_data_in,
    output logic [7:0] ulpi_data_out,
    output logic       ulpi_data_oe,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    output logic       ulpi_stp,
    input  logic       tx_busy,
    input  logic       req,
    output logic       req_ready,
    input  logic       req_rd,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       done,
    output logic       err,
    output logic [7:0] rdata,
    output logic       rxcmd_valid,
    output logic [7:0] rxcmd,
    output logic [1:0] line_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    reg_state_t    state_reg, state_next;
    logic          rd_reg, rd_next;
    logic [7:0]    addr_reg, addr_next;
    logic [7:0]    wdata_reg, wdata_next;
    logic [7:0]    rdata_reg, rdata_next;
    logic [RW-1:0] retry_reg, retry_next;
    logic [TW-1:0] tmo_reg;
    logic          failed_reg, failed_next;
    logic          turn_seen_reg, turn_seen_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;

    logic ext, ext_illegal, waiting, tmo_hit, abort;

    assign ext         = is_ext_addr(addr_reg);
    assign ext_illegal = (EXT_ADDR_EN == 0) && is_ext_addr(req_addr);
    assign req_ready   = (state_reg == IDLE) && !ulpi_dir && !tx_busy;
    assign waiting     = (state_reg == CMD) || (state_reg == EXT_ADDR) || (state_reg == WDATA) ||
                         (state_reg == TURN) || (state_reg == RDATA);
    assign tmo_hit     = (tmo_reg == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next     = state_reg;
        rd_next        = rd_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        rdata_next     = rdata_reg;
        retry_next     = retry_reg;
        failed_next    = failed_reg;
        turn_seen_next = turn_seen_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;
        abort          = 1'b0;
        ulpi_data_out  = 8'h00;
        ulpi_data_oe   = 1'b0;
        ulpi_stp       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req && req_ready) begin
                    rd_next     = req_rd;
                    addr_next   = req_addr;
                    wdata_next  = req_wdata;
                    retry_next  = '0;
                    failed_next = 1'b0;
                    if (ext_illegal) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                        err_next   = 1'b1;
                    end else begin
                        state_next = CMD;
                    end
                end
            end
            CMD: begin
                ulpi_data_oe  = 1'b1;
                ulpi_data_out = {rd_reg ? REGR : REGW, ext ? EXT_ADDR_ESC : addr_reg[5:0]};
                if (ulpi_dir) begin
                    abort = 1'b1;
                end else if (ulpi_nxt) begin
                    state_next = ext ? EXT_ADDR : (rd_reg ? TURN : WDATA);
                end else if (tmo_hit) begin
                    state_next  = STP;
                    failed_next = 1'b1;
                end
            end
            EXT_ADDR: begin
                ulpi_data_oe  = 1'b1;
                ulpi_data_out = addr_reg;
                if (ulpi_dir) begin
                    abort = 1'b1;
                end else if (ulpi_nxt) begin
                    state_next = rd_reg ? TURN : WDATA;
                end else if (tmo_hit) begin
                    state_next  = STP;
                    failed_next = 1'b1;
                end
            end
            WDATA: begin
                ulpi_data_oe  = 1'b1;
                ulpi_data_out = wdata_reg;
                if (ulpi_dir) begin
                    abort = 1'b1;
                end else if (ulpi_nxt || tmo_hit) begin
                    state_next  = STP;
                    failed_next = !ulpi_nxt;
                end
            end
            STP: begin
                ulpi_data_oe = 1'b1;
                ulpi_stp     = 1'b1;
                state_next   = DONE;
                done_next    = 1'b1;
                err_next     = failed_reg;
            end
            TURN: begin
                if (ulpi_dir) begin
                    if (ulpi_nxt) abort = 1'b1;
                    else          state_next = RDATA;
                end else if (tmo_hit) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                end
            end
            RDATA: begin
                if (ulpi_dir && !ulpi_nxt) begin
                    rdata_next = ulpi_data_in;
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    abort = 1'b1;
                end
            end
            DONE: state_next = IDLE;
            WAIT_DIR_LOW: begin
                // One dir-low cycle of turnaround before the link may drive again.
                if (ulpi_dir)            turn_seen_next = 1'b0;
                else if (!turn_seen_reg) turn_seen_next = 1'b1;
                else                     state_next = failed_reg ? IDLE : CMD;
            end
            default: state_next = IDLE;
        endcase

        if (abort) begin
            state_next     = WAIT_DIR_LOW;
            turn_seen_next = 1'b0;
            if (retry_reg >= RW'(MAX_RETRY)) begin
                done_next   = 1'b1;
                err_next    = 1'b1;
                failed_next = 1'b1;
            end else begin
                retry_next = retry_reg + 1'b1;
            end
        end

        if (ulpi_dir) ulpi_data_oe = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            rd_reg        <= 1'b0;
            addr_reg      <= 8'h00;
            wdata_reg     <= 8'h00;
            rdata_reg     <= 8'h00;
            retry_reg     <= '0;
            tmo_reg       <= '0;
            failed_reg    <= 1'b0;
            turn_seen_reg <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rd_reg        <= rd_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            rdata_reg     <= rdata_next;
            retry_reg     <= retry_next;
            failed_reg    <= failed_next;
            turn_seen_reg <= turn_seen_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            tmo_reg       <= (state_next != state_reg || !waiting) ? '0 : tmo_reg + 1'b1;
        end
    end

    assign done  = done_reg;
    assign err   = err_reg;
    assign rdata = rdata_reg;

    ulpi_rxcmd_tracker u_rxcmd (
        .clk          (clk),
        .reset        (reset),
        .ulpi_dir     (ulpi_dir),
        .ulpi_nxt     (ulpi_nxt),
        .ulpi_data_in (ulpi_data_in),
        .capture_en   ((state_reg != TURN) && (state_reg != RDATA)),
        .rxcmd_valid  (rxcmd_valid),
        .rxcmd        (rxcmd),
        .line_state   (line_state)
    );

endmodule

// File: tb/tb_ulpi_reg_ctrl.sv
// Directed bench for ulpi_reg_ctrl: PHY behaviour scripted cycle by cycle, expectations hand-computed.
module tb_ulpi_reg_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ulpi_data_in = 8'h00;
    logic       ulpi_dir = 1'b0;
    logic       ulpi_nxt = 1'b0;
    logic       tx_busy = 1'b0;
    logic       req = 1'b0;
    logic       req2 = 1'b0;
    logic       req_rd = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;

    logic [7:0] data_out, data_out_nx, rdata, rdata_nx, rxcmd, rxcmd_nx;
    logic       oe, oe_nx, stp, stp_nx, ready, ready_nx, done, done_nx, err, err_nx;
    logic       rxv, rxv_nx;
    logic [1:0] line_state, line_state_nx;

    int checks = 0;
    int errors = 0;

    ulpi_reg_ctrl #(.EXT_ADDR_EN(1), .TIMEOUT_CYCLES(64), .MAX_RETRY(3)) u_dut (
        .clk(clk), .reset(reset), .ulpi_data_in(ulpi_data_in), .ulpi_data_out(data_out),
        .ulpi_data_oe(oe), .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt), .ulpi_stp(stp),
        .tx_busy(tx_busy), .req(req), .req_ready(ready), .req_rd(req_rd), .req_addr(req_addr),
        .req_wdata(req_wdata), .done(done), .err(err), .rdata(rdata), .rxcmd_valid(rxv),
        .rxcmd(rxcmd), .line_state(line_state)
    );

    ulpi_reg_ctrl #(.EXT_ADDR_EN(0), .TIMEOUT_CYCLES(64), .MAX_RETRY(3)) u_dut_noext (
        .clk(clk), .reset(reset), .ulpi_data_in(ulpi_data_in), .ulpi_data_out(data_out_nx),
        .ulpi_data_oe(oe_nx), .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt), .ulpi_stp(stp_nx),
        .tx_busy(tx_busy), .req(req2), .req_ready(ready_nx), .req_rd(req_rd), .req_addr(req_addr),
        .req_wdata(req_wdata), .done(done_nx), .err(err_nx), .rdata(rdata_nx), .rxcmd_valid(rxv_nx),
        .rxcmd(rxcmd_nx), .line_state(line_state_nx)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values
        cyc(); cyc(); #1;
        chk("rst_oe", oe, 0);       chk("rst_stp", stp, 0);
        chk("rst_data", data_out, 8'h00);
        chk("rst_done", done, 0);   chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_rxcmd", rxcmd, 8'h00);
        chk("rst_linest", line_state, 0);
        chk("rst_rxv", rxv, 0);
        reset = 1'b0;
        cyc();

        // Write 0x04 <= 0x5A, nxt after two CMD cycles
        req = 1; req_rd = 0; req_addr = 8'h04; req_wdata = 8'h5A; #1;
        chk("w_ready", ready, 1);
        cyc(); req = 0; #1;
        chk("w_cmd_oe", oe, 1);     chk("w_cmd_data", data_out, 8'h84);
        cyc(); cyc(); ulpi_nxt = 1; #1;
        chk("w_cmd_hold", data_out, 8'h84);
        cyc(); #1;
        chk("w_wdata", data_out, 8'h5A);
        cyc(); ulpi_nxt = 0; #1;
        chk("w_stp", stp, 1);       chk("w_stp_data", data_out, 8'h00);
        chk("w_stp_oe", oe, 1);
        cyc(); #1;
        chk("w_done", done, 1);     chk("w_err", err, 0);
        chk("w_stp_end", stp, 0);
        cyc(); #1;
        chk("w_done_end", done, 0);

        // Read 0x04 -> 0xA5
        req = 1; req_rd = 1; req_addr = 8'h04; #1;
        chk("r_ready", ready, 1);
        cyc(); req = 0; ulpi_nxt = 1; #1;
        chk("r_cmd_data", data_out, 8'hC4);
        cyc(); ulpi_nxt = 0; #1;
        chk("r_turn_oe", oe, 0);
        cyc(); ulpi_dir = 1; #1;
        chk("r_turn_dir_oe", oe, 0);
        cyc(); ulpi_data_in = 8'hA5;
        cyc(); ulpi_dir = 0; ulpi_data_in = 8'h00; #1;
        chk("r_done", done, 1);     chk("r_err", err, 0);
        chk("r_rdata", rdata, 8'hA5);
        chk("r_no_rxcmd", rxv, 0);
        cyc();

        // Extended write 0x80 <= 0x11
        req = 1; req_rd = 0; req_addr = 8'h80; req_wdata = 8'h11;
        cyc(); req = 0; ulpi_nxt = 1; #1;
        chk("x_cmd_data", data_out, 8'hAF);
        cyc(); #1;
        chk("x_addr_data", data_out, 8'h80);
        cyc(); #1;
        chk("x_wdata", data_out, 8'h11);
        cyc(); ulpi_nxt = 0; #1;
        chk("x_stp", stp, 1);
        cyc(); #1;
        chk("x_done", done, 1);     chk("x_err", err, 0);
        cyc();

        // Extended address with extension disabled
        req2 = 1; #1;
        chk("nx_ready", ready_nx, 1);
        cyc(); req2 = 0; #1;
        chk("nx_done", done_nx, 1); chk("nx_err", err_nx, 1);
        chk("nx_oe", oe_nx, 0);
        cyc(); #1;
        chk("nx_done_end", done_nx, 0);
        chk("nx_oe_end", oe_nx, 0);

        // dir aborts during CMD: three retries, fourth abort fails
        req = 1; req_rd = 0; req_addr = 8'h04; req_wdata = 8'h5A;
        cyc(); req = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rt_cmd_oe", oe, 1);
            chk("rt_cmd_data", data_out, 8'h84);
            ulpi_dir = 1; #1;
            chk("rt_oe_drop", oe, 0);
            cyc(); ulpi_dir = 0; #1;
            chk("rt_done", done, (k == 3) ? 8'h01 : 8'h00);
            chk("rt_err", err, (k == 3) ? 8'h01 : 8'h00);
            cyc(); cyc();
        end
        #1;
        chk("rt_idle_ready", ready, 1);
        chk("rt_idle_oe", oe, 0);

        // Timeout: PHY never asserts nxt
        req = 1; req_rd = 0; req_addr = 8'h04;
        cyc(); req = 0;
        repeat (63) cyc();
        #1;
        chk("to_cmd64_oe", oe, 1);  chk("to_cmd64_stp", stp, 0);
        cyc(); #1;
        chk("to_stp", stp, 1);      chk("to_stp_done", done, 0);
        cyc(); #1;
        chk("to_done", done, 1);    chk("to_err", err, 1);
        cyc(); #1;
        chk("to_done_end", done, 0);

        // Reset during WDATA
        req = 1; req_rd = 0; req_addr = 8'h04; req_wdata = 8'h5A;
        cyc(); req = 0; ulpi_nxt = 1;
        cyc(); #1;
        chk("rs_wdata", data_out, 8'h5A);
        reset = 1; ulpi_nxt = 0;
        cyc(); #1;
        chk("rs_oe", oe, 0);        chk("rs_stp", stp, 0);
        chk("rs_done", done, 0);
        reset = 0;
        cyc(); #1;
        chk("rs_done_after", done, 0);
        chk("rs_ready", ready, 1);

        // tx_busy blocks requests
        tx_busy = 1; #1;
        chk("busy_ready", ready, 0);
        tx_busy = 0;
        chk("pre_rxcmd", rxcmd, 8'h00);

        // RX CMD while idle, with a request colliding with dir rising
        ulpi_dir = 1; ulpi_data_in = 8'h00; req = 1; #1;
        chk("rx_req_ready", ready, 0);
        cyc(); req = 0; ulpi_data_in = 8'h02; #1;
        chk("rx_turn_valid", rxv, 0);
        chk("rx_no_accept_oe", oe, 0);
        cyc(); ulpi_dir = 0; ulpi_data_in = 8'h00; #1;
        chk("rx_valid", rxv, 1);
        chk("rx_byte", rxcmd, 8'h02);
        chk("rx_linest", line_state, 8'h02);
        chk("rx_no_done", done, 0);
        cyc(); #1;
        chk("rx_valid_end", rxv, 0);
        chk("rx_linest_held", line_state, 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
